// File: rtl/wb_arbiter.sv
// wb_arbiter -- write-back arbiter and pending-write scoreboard.
//
// Shares the single register-file write port among three write-back
// requesters (ALU, LSU, MDU). Grant order is: starved LSU, starved MDU,
// ALU, LSU, MDU. LSU and MDU each keep an age counter. A requester becomes
// "starved" once its age reaches STARVE_LIMIT. The winning write is
// registered onto the port, so the write appears one cycle after the grant.
// A 32-entry scoreboard records destinations issued by id. id uses it to
// stall on RAW hazards.
//
// Optional feature: define WB_ARB_BYPASS_EN to add rs1_fwd/rs2_fwd. With it
// defined, busy is suppressed when the queried register is being written
// this cycle.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   {alu,lsu,mdu}_valid/rd/data write-back request, destination, result
//   {alu,lsu,mdu}_ready         request granted this cycle (combinational)
//   issue_valid, issue_rd       id issues a register-writing instruction
//   rs1_index, rs2_index        hazard queries
//   rs1_busy, rs2_busy          queried register has a pending write
//   rs1_fwd, rs2_fwd            (WB_ARB_BYPASS_EN) take operand from write_data
//   reg_write, write_index, write_data  register-file write port
module wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int RFIDX_WIDTH  = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_valid,
  input  logic [RFIDX_WIDTH-1:0] alu_rd,
  input  logic [XLEN-1:0]        alu_data,
  output logic                   alu_ready,
  input  logic                   lsu_valid,
  input  logic [RFIDX_WIDTH-1:0] lsu_rd,
  input  logic [XLEN-1:0]        lsu_data,
  output logic                   lsu_ready,
  input  logic                   mdu_valid,
  input  logic [RFIDX_WIDTH-1:0] mdu_rd,
  input  logic [XLEN-1:0]        mdu_data,
  output logic                   mdu_ready,
  input  logic                   issue_valid,
  input  logic [RFIDX_WIDTH-1:0] issue_rd,
  input  logic [RFIDX_WIDTH-1:0] rs1_index,
  input  logic [RFIDX_WIDTH-1:0] rs2_index,
  output logic                   rs1_busy,
  output logic                   rs2_busy,
`ifdef WB_ARB_BYPASS_EN
  output logic                   rs1_fwd,
  output logic                   rs2_fwd,
`endif
  output logic                   reg_write,
  output logic [RFIDX_WIDTH-1:0] write_index,
  output logic [XLEN-1:0]        write_data
);

  localparam int NREGS = 1 << RFIDX_WIDTH;
  localparam logic [3:0] AGE_LIMIT = STARVE_LIMIT[3:0];

  logic [3:0]             lsu_age_q, lsu_age_d;
  logic [3:0]             mdu_age_q, mdu_age_d;
  logic                   reg_write_q, reg_write_d;
  logic [RFIDX_WIDTH-1:0] write_index_q, write_index_d;
  logic [XLEN-1:0]        write_data_q, write_data_d;
  logic [NREGS-1:0]       sb_q, sb_d;

  logic                   lsu_starved, mdu_starved;
  logic                   any_gnt;
  logic [RFIDX_WIDTH-1:0] sel_rd;
  logic [XLEN-1:0]        sel_data;

  // Grant selection: starved requesters jump ahead of the ALU.
  always_comb begin
    alu_ready   = 1'b0;
    lsu_ready   = 1'b0;
    mdu_ready   = 1'b0;
    sel_rd      = '0;
    sel_data    = '0;
    lsu_starved = lsu_valid && (lsu_age_q == AGE_LIMIT);
    mdu_starved = mdu_valid && (mdu_age_q == AGE_LIMIT);
    if (lsu_starved) begin
      lsu_ready = 1'b1;
      sel_rd    = lsu_rd;
      sel_data  = lsu_data;
    end else if (mdu_starved) begin
      mdu_ready = 1'b1;
      sel_rd    = mdu_rd;
      sel_data  = mdu_data;
    end else if (alu_valid) begin
      alu_ready = 1'b1;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
    end else if (lsu_valid) begin
      lsu_ready = 1'b1;
      sel_rd    = lsu_rd;
      sel_data  = lsu_data;
    end else if (mdu_valid) begin
      mdu_ready = 1'b1;
      sel_rd    = mdu_rd;
      sel_data  = mdu_data;
    end
    any_gnt = alu_ready | lsu_ready | mdu_ready;
  end

  // Next state: ages, write port, scoreboard.
  always_comb begin
    lsu_age_d = lsu_age_q;
    if (!lsu_valid || lsu_ready)   lsu_age_d = '0;
    else if (lsu_age_q != AGE_LIMIT) lsu_age_d = lsu_age_q + 4'd1;

    mdu_age_d = mdu_age_q;
    if (!mdu_valid || mdu_ready)   mdu_age_d = '0;
    else if (mdu_age_q != AGE_LIMIT) mdu_age_d = mdu_age_q + 4'd1;

    // A grant to x0 is consumed but never reaches the register file.
    reg_write_d   = any_gnt && (sel_rd != '0);
    write_index_d = write_index_q;
    write_data_d  = write_data_q;
    if (reg_write_d) begin
      write_index_d = sel_rd;
      write_data_d  = sel_data;
    end

    // Clear first so that a same-edge issue to the same index wins.
    sb_d = sb_q;
    if (reg_write_q) sb_d[write_index_q] = 1'b0;
    if (issue_valid && (issue_rd != '0)) sb_d[issue_rd] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lsu_age_q     <= '0;
      mdu_age_q     <= '0;
      reg_write_q   <= 1'b0;
      write_index_q <= '0;
      write_data_q  <= '0;
      sb_q          <= '0;
    end else begin
      lsu_age_q     <= lsu_age_d;
      mdu_age_q     <= mdu_age_d;
      reg_write_q   <= reg_write_d;
      write_index_q <= write_index_d;
      write_data_q  <= write_data_d;
      sb_q          <= sb_d;
    end
  end

  assign reg_write   = reg_write_q;
  assign write_index = write_index_q;
  assign write_data  = write_data_q;

`ifdef WB_ARB_BYPASS_EN
  // The write landing this cycle can be forwarded instead of stalling.
  assign rs1_fwd  = reg_write_q && (write_index_q == rs1_index) && (rs1_index != '0);
  assign rs2_fwd  = reg_write_q && (write_index_q == rs2_index) && (rs2_index != '0);
  assign rs1_busy = sb_q[rs1_index] && !rs1_fwd;
  assign rs2_busy = sb_q[rs2_index] && !rs2_fwd;
`else
  assign rs1_busy = sb_q[rs1_index];
  assign rs2_busy = sb_q[rs2_index];
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, lsu_valid, mdu_valid;
  logic [4:0]  alu_rd, lsu_rd, mdu_rd;
  logic [31:0] alu_data, lsu_data, mdu_data;
  logic        alu_ready, lsu_ready, mdu_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd, rs1_index, rs2_index;
  logic        rs1_busy, rs2_busy;
`ifdef WB_ARB_BYPASS_EN
  logic        rs1_fwd, rs2_fwd;
`endif
  logic        reg_write;
  logic [4:0]  write_index;
  logic [31:0] write_data;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(32), .RFIDX_WIDTH(5), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1_index(rs1_index), .rs2_index(rs2_index),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
`ifdef WB_ARB_BYPASS_EN
    .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
`endif
    .reg_write(reg_write), .write_index(write_index), .write_data(write_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    alu_valid = 1'b0; lsu_valid = 1'b0; mdu_valid = 1'b0;
    alu_rd = '0; lsu_rd = '0; mdu_rd = '0;
    alu_data = '0; lsu_data = '0; mdu_data = '0;
    issue_valid = 1'b0; issue_rd = '0; rs1_index = '0; rs2_index = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_reg_write", reg_write, 0);
    chk("rst_write_index", write_index, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_rs1_busy", rs1_busy, 0);
    rst_n = 1'b1;

    // Single ALU write
    tick();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    chk("single_alu_ready", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    chk("single_reg_write", reg_write, 1);
    chk("single_index", write_index, 5);
    chk("single_data", write_data, 32'hDEADBEEF);
    tick();
    chk("single_reg_write_off", reg_write, 0);
    chk("single_data_hold", write_data, 32'hDEADBEEF);

    // Contention ALU vs LSU
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h22;
    #1;
    chk("cont_c0_alu_ready", alu_ready, 1);
    chk("cont_c0_lsu_ready", lsu_ready, 0);
    tick();
    alu_valid = 1'b0;
    #1;
    chk("cont_c1_lsu_ready", lsu_ready, 1);
    chk("cont_c1_reg_write", reg_write, 1);
    chk("cont_c1_index", write_index, 3);
    chk("cont_c1_data", write_data, 32'h11);
    tick();
    lsu_valid = 1'b0;
    chk("cont_c2_index", write_index, 4);
    chk("cont_c2_data", write_data, 32'h22);
    tick();

    // Starvation: LSU promoted after 4 denied cycles
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h2;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("starve_c%0d_lsu_ready", c), lsu_ready, 0);
      tick();
    end
    #1;
    chk("starve_c4_lsu_ready", lsu_ready, 1);
    chk("starve_c4_alu_ready", alu_ready, 0);
    tick();
    #1;
    chk("starve_c5_alu_ready", alu_ready, 1);
    chk("starve_c5_lsu_ready", lsu_ready, 0);
    chk("starve_c5_index", write_index, 2);
    chk("starve_c5_data", write_data, 32'h2);
    tick();
    alu_valid = 1'b0; lsu_valid = 1'b0;

    // x0 discard (port currently writing x1 from the previous ALU grant)
    mdu_valid = 1'b1; mdu_rd = 5'd0; mdu_data = 32'h55;
    rs1_index = 5'd0;
    #1;
    chk("x0_mdu_ready", mdu_ready, 1);
    tick();
    mdu_valid = 1'b0;
    #1;
    chk("x0_reg_write", reg_write, 0);
    chk("x0_index_hold", write_index, 1);
    chk("x0_rs1_busy", rs1_busy, 0);
    tick();

    // Scoreboard
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0; rs1_index = 5'd7;
    #1;
    chk("sb_set_busy", rs1_busy, 1);
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h77;
    #1;
    chk("sb_mdu_ready", mdu_ready, 1);
    tick();
    mdu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    chk("sb_wr_reg_write", reg_write, 1);
`ifdef WB_ARB_BYPASS_EN
    chk("sb_wr_busy_bypass", rs1_busy, 0);
    chk("sb_wr_fwd", rs1_fwd, 1);
`else
    chk("sb_wr_busy", rs1_busy, 1);
`endif
    tick();
    issue_valid = 1'b0;
    #1;
    chk("sb_set_wins", rs1_busy, 1);
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h88;
    tick();
    mdu_valid = 1'b0;
    chk("sb_wr2_data", write_data, 32'h88);
    tick();
    chk("sb_cleared", rs1_busy, 0);

    // Reset mid-operation
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    issue_rd = 5'd10;
    tick();
    issue_rd = 5'd11;
    tick();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hABCD;
    rs1_index = 5'd9; rs2_index = 5'd11;
    tick();
    alu_valid = 1'b0;
    chk("mid_reg_write", reg_write, 1);
    chk("mid_rs1_busy", rs1_busy, 1);
    chk("mid_rs2_busy", rs2_busy, 1);
    #1;
    rst_n = 1'b0;
    alu_valid = 1'b1;
    #1;
    chk("arst_reg_write", reg_write, 0);
    chk("arst_index", write_index, 0);
    chk("arst_data", write_data, 0);
    chk("arst_rs1_busy", rs1_busy, 0);
    chk("arst_rs2_busy", rs2_busy, 0);
    chk("arst_alu_ready", alu_ready, 1);
    alu_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    rs1_index = 5'd10;
    alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'hCAFE;
    #1;
    chk("post_rs1_busy", rs1_busy, 0);
    chk("post_alu_ready", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    chk("post_reg_write", reg_write, 1);
    chk("post_index", write_index, 13);
    chk("post_data", write_data, 32'hCAFE);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
